pu_riscv_biu_arbiter: RTL and testbench
=======================================

Name: pu_riscv_biu_arbiter

Overview:
- Two-requester arbiter that shares one BIU master port between the data-memory BIU (port 0) and the instruction-memory BIU (port 1).
- The master port drives the BIU-to-AHB3-Lite bridge.
- Grants one owner at a time and holds ownership until that owner's accepted transfers have been fully acknowledged.
- Round-robin fairness under contention; HMASTLOCK-style lock honoured; ack/data/error responses routed back to the owner.

Parameters:
- XLEN, 64, data width.
- PLEN, 64, physical address width.

Ports:
- HCLK  in  1  clock. Reset is HRESETn: asynchronous, active-low.
- HRESETn  in  1  asynchronous active-low reset.
- sN_biu_stb_i  in  1  requester N strobe (N=0,1; same for all sN_ lines below).
- sN_biu_stb_ack_o  out  1  strobe accepted for requester N.
- sN_biu_d_ack_o  out  1  write-data acknowledge to requester N.
- sN_biu_adri_i  in  PLEN  request address.
- sN_biu_adro_o  out  PLEN  address of the current data beat.
- sN_biu_size_i  in  3  transfer size.
- sN_biu_type_i  in  3  burst type (peripheral_biu_pkg encoding).
- sN_biu_prot_i  in  3  protection.
- sN_biu_lock_i  in  1  lock request.
- sN_biu_we_i  in  1  write enable.
- sN_biu_d_i  in  XLEN  write data.
- sN_biu_q_o  out  XLEN  read data.
- sN_biu_ack_o  out  1  transfer acknowledge.
- sN_biu_err_o  out  1  transfer error.
- m_biu_* (stb, stb_ack, d_ack, adri, adro, size, type, prot, lock, we, d, q, ack, err): master-side mirror of the sN_ set, opposite directions, same widths.

Behaviour:
- Registers:
  - state: IDLE, BUSY, DRAIN.
  - owner: 1 bit.
  - last: 1 bit, last granted port.
  - pend: 5-bit outstanding-beat counter.
- Reset values: state=IDLE, owner=0, last=1 (port 0 wins the first tie), pend=0.
  - All sN_ ack/stb_ack/d_ack/err outputs = 0; m_biu_stb_o = 0, m_biu_lock_o = 0.
- IDLE:
  - m_biu_stb_o = 0.
  - If exactly one port strobes, grant it. If both strobe, grant ~last.
  - Next cycle: state=BUSY, owner and last = granted port. Arbitration latency is 1 cycle.
- BUSY:
  - All m_ request fields are muxed combinationally from the owner; m_biu_stb_o = owner stb.
  - m_biu_stb_ack_i and m_biu_d_ack_i are routed to the owner only; the non-owner sees 0.
- Accepted strobe (m_stb & m_stb_ack) adds beats to pend:
  - SINGLE/INCR = 1; WRAP4/INCR4 = 4; WRAP8/INCR8 = 8; WRAP16/INCR16 = 16.
  - Each m_biu_ack_i decrements pend by 1.
  - Simultaneous accept and ack: pend = pend + beats - 1.
  - pend never underflows; an ack with pend=0 is ignored.
- BUSY to DRAIN: on an accepted strobe while the other port strobes and owner lock=0.
- BUSY to IDLE: when pend (next value) = 0 and owner stb=0.
- Locked owner: stays in BUSY regardless of contention.
- DRAIN:
  - m_biu_stb_o forced 0; responses still routed to owner.
  - Leave to IDLE when pend (next value) = 0.
- Response routing:
  - m_biu_ack_i and m_biu_err_i go to the owner only, in BUSY and DRAIN.
  - sN_biu_q_o = m_biu_q_i for both ports; sN_biu_adro_o = m_biu_adro_i for both ports.
  - In IDLE, all sN_ acks and errs are 0.
- Error: m_biu_err_i in BUSY or DRAIN forces pend=0 and state=IDLE. The owner receives err for that cycle; in-flight beats are abandoned.
- m_biu_lock_o = owner lock in BUSY, 0 otherwise.
- Asynchronous reset mid-burst returns all registers to their reset values immediately; there is no response replay.

Test Plan:
- Port 0 SINGLE read at 0x1000, port 1 idle:
  - grant 1 cycle after stb; s0_stb_ack with m_stb_ack; s0_ack on the single m_ack.
  - State returns to IDLE; s1 outputs stay 0 throughout.
- Both ports strobe SINGLE in the same cycle after reset:
  - port 0 served first, then port 1.
  - Repeat with both strobing: port 0 is served again only after port 1 (round robin; last toggles).
- Port 1 INCR8 while port 0 requests:
  - pend=8 after accept; state enters DRAIN.
  - Port 0 is granted only after the 8th m_ack; no port 1 stb_ack occurs during DRAIN.
- Port 0 locked back-to-back SINGLE writes while port 1 strobes:
  - port 0 keeps the grant for all locked transfers; m_lock=1.
  - Port 1 is granted only after port 0 drops stb and lock.
- Port 0 WRAP4 read, m_err on the 2nd beat:
  - s0_err=1 for one cycle; pend=0; IDLE next cycle; waiting port 1 granted after that.
- HRESETn asserted with pend=5 in BUSY:
  - all outputs 0 immediately; after release, the first request is granted normally with pend starting from 0.

Source files
------------

// File: rtl/pu_riscv_biu_arbiter.sv
// Two-port BIU arbiter: shares one BIU master port between the data-memory BIU
// (port 0) and the instruction-memory BIU (port 1), round-robin with lock support.
module pu_riscv_biu_arbiter #(
    parameter int XLEN = 64,
    parameter int PLEN = 64
) (
    input  logic            HCLK,
    input  logic            HRESETn,

    input  logic            s0_biu_stb_i,
    output logic            s0_biu_stb_ack_o,
    output logic            s0_biu_d_ack_o,
    input  logic [PLEN-1:0] s0_biu_adri_i,
    output logic [PLEN-1:0] s0_biu_adro_o,
    input  logic [2:0]      s0_biu_size_i,
    input  logic [2:0]      s0_biu_type_i,
    input  logic [2:0]      s0_biu_prot_i,
    input  logic            s0_biu_lock_i,
    input  logic            s0_biu_we_i,
    input  logic [XLEN-1:0] s0_biu_d_i,
    output logic [XLEN-1:0] s0_biu_q_o,
    output logic            s0_biu_ack_o,
    output logic            s0_biu_err_o,

    input  logic            s1_biu_stb_i,
    output logic            s1_biu_stb_ack_o,
    output logic            s1_biu_d_ack_o,
    input  logic [PLEN-1:0] s1_biu_adri_i,
    output logic [PLEN-1:0] s1_biu_adro_o,
    input  logic [2:0]      s1_biu_size_i,
    input  logic [2:0]      s1_biu_type_i,
    input  logic [2:0]      s1_biu_prot_i,
    input  logic            s1_biu_lock_i,
    input  logic            s1_biu_we_i,
    input  logic [XLEN-1:0] s1_biu_d_i,
    output logic [XLEN-1:0] s1_biu_q_o,
    output logic            s1_biu_ack_o,
    output logic            s1_biu_err_o,

    output logic            m_biu_stb_o,
    input  logic            m_biu_stb_ack_i,
    input  logic            m_biu_d_ack_i,
    output logic [PLEN-1:0] m_biu_adri_o,
    input  logic [PLEN-1:0] m_biu_adro_i,
    output logic [2:0]      m_biu_size_o,
    output logic [2:0]      m_biu_type_o,
    output logic [2:0]      m_biu_prot_o,
    output logic            m_biu_lock_o,
    output logic            m_biu_we_o,
    output logic [XLEN-1:0] m_biu_d_o,
    input  logic [XLEN-1:0] m_biu_q_i,
    input  logic            m_biu_ack_i,
    input  logic            m_biu_err_i
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [2:0] BT_SINGLE = 3'd0;
    localparam logic [2:0] BT_INCR   = 3'd1;
    localparam logic [2:0] BT_WRAP4  = 3'd2;
    localparam logic [2:0] BT_INCR4  = 3'd3;
    localparam logic [2:0] BT_WRAP8  = 3'd4;
    localparam logic [2:0] BT_INCR8  = 3'd5;
    localparam logic [2:0] BT_WRAP16 = 3'd6;
    localparam logic [2:0] BT_INCR16 = 3'd7;

    logic [1:0] r_state;
    logic       r_owner;
    logic       r_last;
    logic [4:0] r_pend;

    logic [1:0] w_state_nxt;
    logic [4:0] w_pend_sum;
    logic [4:0] w_pend_nxt;
    logic [4:0] w_beats;
    logic       w_busy;
    logic       w_active;
    logic       w_own_stb;
    logic       w_own_lock;
    logic       w_oth_stb;
    logic       w_accept;
    logic       w_any_req;
    logic       w_grant;

    assign w_busy     = (r_state == ST_BUSY);
    assign w_active   = (r_state == ST_BUSY) || (r_state == ST_DRAIN);
    assign w_own_stb  = r_owner ? s1_biu_stb_i  : s0_biu_stb_i;
    assign w_own_lock = r_owner ? s1_biu_lock_i : s0_biu_lock_i;
    assign w_oth_stb  = r_owner ? s0_biu_stb_i  : s1_biu_stb_i;
    assign w_accept   = w_busy & w_own_stb & m_biu_stb_ack_i;
    assign w_any_req  = s0_biu_stb_i | s1_biu_stb_i;
    // On a tie the port that did not win last time is granted.
    assign w_grant    = (s0_biu_stb_i & s1_biu_stb_i) ? ~r_last : s1_biu_stb_i;

    // Request fields always follow the owner; only the strobe and lock are gated.
    assign m_biu_adri_o = r_owner ? s1_biu_adri_i : s0_biu_adri_i;
    assign m_biu_size_o = r_owner ? s1_biu_size_i : s0_biu_size_i;
    assign m_biu_type_o = r_owner ? s1_biu_type_i : s0_biu_type_i;
    assign m_biu_prot_o = r_owner ? s1_biu_prot_i : s0_biu_prot_i;
    assign m_biu_we_o   = r_owner ? s1_biu_we_i   : s0_biu_we_i;
    assign m_biu_d_o    = r_owner ? s1_biu_d_i    : s0_biu_d_i;
    assign m_biu_stb_o  = w_busy & w_own_stb;
    assign m_biu_lock_o = w_busy & w_own_lock;

    assign s0_biu_stb_ack_o = w_accept & ~r_owner;
    assign s1_biu_stb_ack_o = w_accept &  r_owner;
    assign s0_biu_d_ack_o   = w_active & ~r_owner & m_biu_d_ack_i;
    assign s1_biu_d_ack_o   = w_active &  r_owner & m_biu_d_ack_i;
    assign s0_biu_ack_o     = w_active & ~r_owner & m_biu_ack_i;
    assign s1_biu_ack_o     = w_active &  r_owner & m_biu_ack_i;
    assign s0_biu_err_o     = w_active & ~r_owner & m_biu_err_i;
    assign s1_biu_err_o     = w_active &  r_owner & m_biu_err_i;
    assign s0_biu_q_o       = m_biu_q_i;
    assign s1_biu_q_o       = m_biu_q_i;
    assign s0_biu_adro_o    = m_biu_adro_i;
    assign s1_biu_adro_o    = m_biu_adro_i;

    always_comb begin
        // NOTE: default assignment first so every path drives w_beats and no latch is inferred.
        w_beats = 5'd1;
        case (m_biu_type_o)
            BT_SINGLE, BT_INCR:   w_beats = 5'd1;
            BT_WRAP4,  BT_INCR4:  w_beats = 5'd4;
            BT_WRAP8,  BT_INCR8:  w_beats = 5'd8;
            BT_WRAP16, BT_INCR16: w_beats = 5'd16;
            default:              w_beats = 5'd1;
        endcase
    end

    // An ack with nothing outstanding is dropped, so the counter never wraps below zero.
    assign w_pend_sum = r_pend + (w_accept ? w_beats : 5'd0);

    always_comb begin
        w_pend_nxt = w_pend_sum;
        if (w_active && m_biu_err_i) begin
            w_pend_nxt = 5'd0;
        end else if (w_active && m_biu_ack_i && (w_pend_sum != 5'd0)) begin
            w_pend_nxt = w_pend_sum - 5'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) w_state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                if (m_biu_err_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_accept && w_oth_stb && !w_own_lock) begin
                    w_state_nxt = ST_DRAIN;
                end else if ((w_pend_nxt == 5'd0) && !w_own_stb) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (m_biu_err_i || (w_pend_nxt == 5'd0)) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // r_last resets to 1 so port 0 wins the first tie after reset.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_pend  <= 5'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            if ((r_state == ST_IDLE) && w_any_req) begin
                r_owner <= w_grant;
                r_last  <= w_grant;
            end
        end
    end

endmodule

// File: tb/tb_pu_riscv_biu_arbiter.sv
// Bench for pu_riscv_biu_arbiter: directed scenarios with fixed expectations and
// a randomized run checked against a transaction-level model of the arbitration rules.
module tb_pu_riscv_biu_arbiter;

    localparam int XLEN = 64;
    localparam int PLEN = 64;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    logic            s0_stb, s0_stb_ack, s0_d_ack, s0_lock, s0_we, s0_ack, s0_err;
    logic [PLEN-1:0] s0_adri, s0_adro;
    logic [2:0]      s0_size, s0_typ, s0_prot;
    logic [XLEN-1:0] s0_d, s0_q;
    logic            s1_stb, s1_stb_ack, s1_d_ack, s1_lock, s1_we, s1_ack, s1_err;
    logic [PLEN-1:0] s1_adri, s1_adro;
    logic [2:0]      s1_size, s1_typ, s1_prot;
    logic [XLEN-1:0] s1_d, s1_q;
    logic            m_stb, m_stb_ack, m_d_ack, m_lock, m_we, m_ack, m_err;
    logic [PLEN-1:0] m_adri, m_adro;
    logic [2:0]      m_size, m_typ, m_prot;
    logic [XLEN-1:0] m_d, m_q;

    int total = 0;
    int bad = 0;

    pu_riscv_biu_arbiter #(.XLEN(XLEN), .PLEN(PLEN)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .s0_biu_stb_i(s0_stb), .s0_biu_stb_ack_o(s0_stb_ack), .s0_biu_d_ack_o(s0_d_ack),
        .s0_biu_adri_i(s0_adri), .s0_biu_adro_o(s0_adro), .s0_biu_size_i(s0_size),
        .s0_biu_type_i(s0_typ), .s0_biu_prot_i(s0_prot), .s0_biu_lock_i(s0_lock),
        .s0_biu_we_i(s0_we), .s0_biu_d_i(s0_d), .s0_biu_q_o(s0_q),
        .s0_biu_ack_o(s0_ack), .s0_biu_err_o(s0_err),
        .s1_biu_stb_i(s1_stb), .s1_biu_stb_ack_o(s1_stb_ack), .s1_biu_d_ack_o(s1_d_ack),
        .s1_biu_adri_i(s1_adri), .s1_biu_adro_o(s1_adro), .s1_biu_size_i(s1_size),
        .s1_biu_type_i(s1_typ), .s1_biu_prot_i(s1_prot), .s1_biu_lock_i(s1_lock),
        .s1_biu_we_i(s1_we), .s1_biu_d_i(s1_d), .s1_biu_q_o(s1_q),
        .s1_biu_ack_o(s1_ack), .s1_biu_err_o(s1_err),
        .m_biu_stb_o(m_stb), .m_biu_stb_ack_i(m_stb_ack), .m_biu_d_ack_i(m_d_ack),
        .m_biu_adri_o(m_adri), .m_biu_adro_i(m_adro), .m_biu_size_o(m_size),
        .m_biu_type_o(m_typ), .m_biu_prot_o(m_prot), .m_biu_lock_o(m_lock),
        .m_biu_we_o(m_we), .m_biu_d_o(m_d), .m_biu_q_i(m_q),
        .m_biu_ack_i(m_ack), .m_biu_err_i(m_err)
    );

    // Handshake flags: {m_stb, m_lock, s0_stb_ack, s1_stb_ack, s0_ack, s1_ack, s0_err, s1_err}
    function automatic logic [7:0] flags();
        return {m_stb, m_lock, s0_stb_ack, s1_stb_ack, s0_ack, s1_ack, s0_err, s1_err};
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic clear_inputs();
        s0_stb = 0; s0_adri = '0; s0_size = 3'd3; s0_typ = 3'd0; s0_prot = 3'd0;
        s0_lock = 0; s0_we = 0; s0_d = '0;
        s1_stb = 0; s1_adri = '0; s1_size = 3'd3; s1_typ = 3'd0; s1_prot = 3'd0;
        s1_lock = 0; s1_we = 0; s1_d = '0;
        m_stb_ack = 0; m_d_ack = 0; m_adro = '0; m_q = '0; m_ack = 0; m_err = 0;
    endtask

    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    task automatic sample();
        @(negedge HCLK);
    endtask

    task automatic apply_reset();
        HRESETn = 0;
        clear_inputs();
        next_cycle();
        next_cycle();
        HRESETn = 1;
    endtask

    task automatic test_reset();
        HRESETn = 0;
        clear_inputs();
        s0_stb = 1; s0_lock = 1; s1_stb = 1;
        m_stb_ack = 1; m_d_ack = 1; m_ack = 1; m_err = 1;
        m_q = rand64(); m_adro = rand64();
        sample();
        total++;
        if (flags() !== 8'b0000_0000) begin
            bad++; $display("FAIL reset_flags got=%b exp=%b", flags(), 8'b0);
        end
        total++;
        if ({s0_d_ack, s1_d_ack} !== 2'b00) begin
            bad++; $display("FAIL reset_d_ack got=%b exp=00", {s0_d_ack, s1_d_ack});
        end
        total++;
        if (s0_q !== m_q || s1_q !== m_q || s1_adro !== m_adro) begin
            bad++; $display("FAIL reset_broadcast q0=%h q1=%h exp=%h", s0_q, s1_q, m_q);
        end
        clear_inputs();
        next_cycle();
        HRESETn = 1;
        next_cycle();
    endtask

    task automatic test_single();
        logic [63:0] q;
        apply_reset();
        s0_stb = 1; s0_adri = 64'h1000; s0_typ = 3'd0; m_stb_ack = 1;
        sample();
        total++;
        if (flags() !== 8'b0000_0000) begin
            bad++; $display("FAIL single_idle got=%b exp=%b", flags(), 8'b0);
        end
        next_cycle();
        sample();
        total++;
        if (flags() !== 8'b1010_0000 || m_adri !== 64'h1000 || m_we !== 1'b0) begin
            bad++; $display("FAIL single_grant flags=%b adri=%h exp=10100000 adri=1000", flags(), m_adri);
        end
        next_cycle();
        s0_stb = 0; m_stb_ack = 0; m_ack = 1; q = rand64(); m_q = q;
        sample();
        total++;
        if (flags() !== 8'b0000_1000 || s0_q !== q) begin
            bad++; $display("FAIL single_ack flags=%b q=%h exp=00001000 q=%h", flags(), s0_q, q);
        end
        next_cycle();
        sample();
        total++;
        if (flags() !== 8'b0000_0000) begin
            bad++; $display("FAIL single_stray_ack_idle got=%b exp=%b", flags(), 8'b0);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_round_robin();
        int grants[$];
        int first_cyc;
        apply_reset();
        first_cyc = -1;
        s0_stb = 1; s1_stb = 1; s0_adri = 64'hA0; s1_adri = 64'hB0;
        m_stb_ack = 1; m_ack = 1;
        for (int c = 0; c < 40 && grants.size() < 4; c++) begin
            sample();
            if (s0_stb_ack || s1_stb_ack) begin
                if (first_cyc < 0) first_cyc = c;
                grants.push_back(s1_stb_ack ? 1 : 0);
                total++;
                if ((s0_stb_ack && s1_stb_ack) || m_adri !== (s1_stb_ack ? 64'hB0 : 64'hA0)) begin
                    bad++; $display("FAIL rr_single_owner acks=%b%b adri=%h", s0_stb_ack, s1_stb_ack, m_adri);
                end
            end
            next_cycle();
        end
        total++;
        if (first_cyc != 1) begin
            bad++; $display("FAIL rr_latency got=%0d exp=1", first_cyc);
        end
        total++;
        if (grants.size() != 4) begin
            bad++; $display("FAIL rr_timeout grants=%0d exp=4", grants.size());
        end
        for (int i = 0; i < grants.size(); i++) begin
            total++;
            if (grants[i] != i % 2) begin
                bad++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i, grants[i], i % 2);
            end
        end
        clear_inputs();
    endtask

    task automatic test_drain();
        apply_reset();
        s1_stb = 1; s1_typ = 3'd5; s1_adri = 64'h2000; m_stb_ack = 1;
        sample();
        next_cycle();
        s0_stb = 1; s0_typ = 3'd0; s0_adri = 64'h3000;
        sample();
        total++;
        if (flags() !== 8'b1001_0000 || m_adri !== 64'h2000) begin
            bad++; $display("FAIL drain_accept flags=%b adri=%h exp=10010000 adri=2000", flags(), m_adri);
        end
        next_cycle();
        for (int b = 0; b < 8; b++) begin
            m_ack = (b == 7) ? 1'b0 : 1'b1;
            sample();
            total++;
            if (flags() !== {5'b0000_0, m_ack, 2'b00}) begin
                bad++; $display("FAIL drain_beat%0d flags=%b exp=%b", b, flags(), {5'b0, m_ack, 2'b0});
            end
            next_cycle();
        end
        m_ack = 1;
        sample();
        total++;
        if (flags() !== 8'b0000_0100) begin
            bad++; $display("FAIL drain_last_beat flags=%b exp=00000100", flags());
        end
        next_cycle();
        m_ack = 0;
        sample();
        total++;
        if (flags() !== 8'b0000_0000) begin
            bad++; $display("FAIL drain_idle flags=%b exp=00000000", flags());
        end
        next_cycle();
        sample();
        total++;
        if (flags() !== 8'b1010_0000 || m_adri !== 64'h3000) begin
            bad++; $display("FAIL drain_regrant flags=%b adri=%h exp=10100000 adri=3000", flags(), m_adri);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_lock();
        apply_reset();
        s0_stb = 1; s0_lock = 1; s0_we = 1; s1_stb = 1; s1_we = 0;
        m_stb_ack = 1; m_ack = 1;
        sample();
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            s0_adri = 64'h100 + 64'(i * 8); s0_d = rand64();
            sample();
            total++;
            if (flags() !== 8'b1110_1000 || m_d !== s0_d || m_we !== 1'b1) begin
                bad++; $display("FAIL lock_xfer%0d flags=%b d=%h exp=11101000 d=%h", i, flags(), m_d, s0_d);
            end
            next_cycle();
        end
        s0_stb = 0; s0_lock = 0; m_ack = 0;
        sample();
        total++;
        if (flags() !== 8'b0000_0000) begin
            bad++; $display("FAIL lock_release flags=%b exp=00000000", flags());
        end
        next_cycle();
        sample();
        next_cycle();
        sample();
        total++;
        if (flags() !== 8'b1001_0000 || m_we !== 1'b0) begin
            bad++; $display("FAIL lock_port1_grant flags=%b we=%b exp=10010000 we=0", flags(), m_we);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_error();
        apply_reset();
        s0_stb = 1; s0_typ = 3'd2; s0_adri = 64'h4000; m_stb_ack = 1;
        sample();
        next_cycle();
        sample();
        total++;
        if (flags() !== 8'b1010_0000) begin
            bad++; $display("FAIL err_accept flags=%b exp=10100000", flags());
        end
        next_cycle();
        s0_stb = 0; m_stb_ack = 0; s1_stb = 1; s1_adri = 64'h5000; m_ack = 1;
        sample();
        total++;
        if (flags() !== 8'b0000_1000) begin
            bad++; $display("FAIL err_beat1 flags=%b exp=00001000", flags());
        end
        next_cycle();
        m_ack = 0; m_err = 1;
        sample();
        total++;
        if (flags() !== 8'b0000_0010) begin
            bad++; $display("FAIL err_route flags=%b exp=00000010", flags());
        end
        next_cycle();
        m_err = 0; m_stb_ack = 1;
        sample();
        total++;
        if (flags() !== 8'b0000_0000) begin
            bad++; $display("FAIL err_idle flags=%b exp=00000000", flags());
        end
        next_cycle();
        sample();
        total++;
        if (flags() !== 8'b1001_0000 || m_adri !== 64'h5000) begin
            bad++; $display("FAIL err_port1_grant flags=%b adri=%h exp=10010000 adri=5000", flags(), m_adri);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_async_reset();
        apply_reset();
        s0_stb = 1; s0_typ = 3'd5; m_stb_ack = 1;
        sample();
        next_cycle();
        sample();
        next_cycle();
        s0_stb = 0; m_stb_ack = 0; m_ack = 1;
        repeat (3) begin
            sample();
            next_cycle();
        end
        s0_stb = 1; s0_lock = 1;
        #1;
        total++;
        if (flags() !== 8'b1100_1000) begin
            bad++; $display("FAIL arst_before flags=%b exp=11001000", flags());
        end
        HRESETn = 0;
        #1;
        total++;
        if (flags() !== 8'b0000_0000) begin
            bad++; $display("FAIL arst_immediate flags=%b exp=00000000", flags());
        end
        clear_inputs();
        next_cycle();
        next_cycle();
        HRESETn = 1;
        s0_stb = 1; s0_typ = 3'd0; m_stb_ack = 1;
        sample();
        next_cycle();
        sample();
        total++;
        if (flags() !== 8'b1010_0000) begin
            bad++; $display("FAIL arst_regrant flags=%b exp=10100000", flags());
        end
        next_cycle();
        s0_stb = 0; m_stb_ack = 0; m_ack = 1;
        sample();
        next_cycle();
        m_ack = 0; s1_stb = 1; m_stb_ack = 1;
        sample();
        next_cycle();
        sample();
        total++;
        if (flags() !== 8'b1001_0000) begin
            bad++; $display("FAIL arst_pend_cleared flags=%b exp=10010000", flags());
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_random();
        int burst_len[8] = '{1, 1, 4, 4, 8, 8, 16, 16};
        bit md_held, md_drain, serving, acc;
        int md_owner, md_last, md_beats, o, sum;
        logic st[2];
        logic lk[2];
        logic [2:0] ty[2];
        logic [7:0] exp_flags;
        logic [PLEN-1:0] exp_adri;
        apply_reset();
        md_held = 0; md_drain = 0; md_owner = 0; md_last = 1; md_beats = 0;
        for (int c = 0; c < 2000; c++) begin
            s0_stb = 1'($urandom_range(0, 1)); s1_stb = 1'($urandom_range(0, 1));
            // keep outstanding beats within the counter's range
            if (md_held && md_beats >= 14) begin
                if (md_owner == 0) s0_stb = 0; else s1_stb = 0;
            end
            s0_lock = ($urandom_range(0, 4) == 0); s1_lock = ($urandom_range(0, 4) == 0);
            s0_typ = 3'($urandom_range(0, 7)); s1_typ = 3'($urandom_range(0, 7));
            s0_adri = rand64(); s1_adri = rand64(); s0_d = rand64(); s1_d = rand64();
            s0_we = 1'($urandom_range(0, 1)); s1_we = 1'($urandom_range(0, 1));
            m_stb_ack = ($urandom_range(0, 9) < 6); m_ack = ($urandom_range(0, 9) < 7);
            m_err = ($urandom_range(0, 31) == 0); m_d_ack = 1'($urandom_range(0, 1));
            m_q = rand64(); m_adro = rand64();
            sample();
            st[0] = s0_stb; st[1] = s1_stb; lk[0] = s0_lock; lk[1] = s1_lock;
            ty[0] = s0_typ; ty[1] = s1_typ;
            o = md_owner;
            serving = md_held && !md_drain;
            acc = serving && st[o] && m_stb_ack;
            exp_flags = {serving && st[o], serving && lk[o], acc && o == 0, acc && o == 1,
                         md_held && o == 0 && m_ack, md_held && o == 1 && m_ack,
                         md_held && o == 0 && m_err, md_held && o == 1 && m_err};
            total++;
            if (flags() !== exp_flags) begin
                bad++; $display("FAIL rand_flags cyc=%0d got=%b exp=%b", c, flags(), exp_flags);
            end
            total++;
            if ({s0_d_ack, s1_d_ack} !== {md_held && o == 0 && m_d_ack, md_held && o == 1 && m_d_ack}) begin
                bad++; $display("FAIL rand_d_ack cyc=%0d got=%b%b", c, s0_d_ack, s1_d_ack);
            end
            total++;
            if (s0_q !== m_q || s1_q !== m_q || s0_adro !== m_adro || s1_adro !== m_adro) begin
                bad++; $display("FAIL rand_broadcast cyc=%0d q0=%h q1=%h exp=%h", c, s0_q, s1_q, m_q);
            end
            if (serving) begin
                exp_adri = (o == 1) ? s1_adri : s0_adri;
                total++;
                if (m_adri !== exp_adri || m_typ !== ty[o] || m_d !== ((o == 1) ? s1_d : s0_d)) begin
                    bad++; $display("FAIL rand_req_mux cyc=%0d adri=%h exp=%h", c, m_adri, exp_adri);
                end
            end
            // advance the model by one clock
            if (!md_held) begin
                if (st[0] || st[1]) begin
                    md_owner = (st[0] && st[1]) ? 1 - md_last : (st[1] ? 1 : 0);
                    md_last = md_owner;
                    md_held = 1;
                end
            end else if (m_err) begin
                md_held = 0; md_drain = 0; md_beats = 0;
            end else begin
                sum = md_beats + (acc ? burst_len[ty[o]] : 0);
                if (m_ack && sum > 0) sum = sum - 1;
                md_beats = sum;
                if (!md_drain) begin
                    if (acc && st[1 - o] && !lk[o]) md_drain = 1;
                    else if (md_beats == 0 && !st[o]) md_held = 0;
                end else if (md_beats == 0) begin
                    md_held = 0; md_drain = 0;
                end
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_drain();
        test_lock();
        test_error();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
